// File: rtl/cmp32_seq_if.sv
// Operand/result handshake bundle for the sequential 32-bit comparator.
// The master side produces operand pairs and consumes results; the slave side is the comparator.
interface cmp32_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;
    logic        equal;
    logic        lt;
    logic        ltu;
    logic        busy;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, equal, lt, ltu, busy
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, equal, lt, ltu, busy
    );
endinterface

// File: rtl/cmp32_seq.sv
// Multi-cycle 32-bit comparator: one CHUNK_W-bit slice per cycle, MSB chunk first.
// Optional macro CMP32_EARLY_EXIT_EN finishes on the first differing chunk.
module cmp32_seq #(
    parameter int CHUNK_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    cmp32_seq_if.slave  bus
);
    localparam int NCH   = 32 / CHUNK_W;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        x_q, x_d;
    logic [31:0]        y_q, y_d;
    logic               eq_q, eq_d;
    logic               lt_q, lt_d;
    logic               ltu_q, ltu_d;
    logic               decided_q, decided_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Operands are shifted left each RUN cycle, so the chunk under test is always the top slice.
    logic [CHUNK_W-1:0] xc_s;
    logic [CHUNK_W-1:0] yc_s;
    logic               chunk_diff_s;
    logic               chunk_ltu_s;
    logic               chunk_lts_s;

    assign xc_s         = x_q[31 -: CHUNK_W];
    assign yc_s         = y_q[31 -: CHUNK_W];
    assign chunk_diff_s = (xc_s != yc_s);
    assign chunk_ltu_s  = (xc_s < yc_s);
    assign chunk_lts_s  = ($signed(xc_s) < $signed(yc_s));

    assign bus.in_ready  = (state_q == ST_IDLE) & ~rst;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.equal     = eq_q;
    assign bus.lt        = lt_q;
    assign bus.ltu       = ltu_q;

    // Next-state and result update logic
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        eq_d        = eq_q;
        lt_d        = lt_q;
        ltu_d       = ltu_q;
        decided_d   = decided_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    x_d       = bus.x;
                    y_d       = bus.y;
                    eq_d      = 1'b1;
                    lt_d      = 1'b0;
                    ltu_d     = 1'b0;
                    decided_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                x_d   = x_q << CHUNK_W;
                y_d   = y_q << CHUNK_W;
                cnt_d = cnt_q + CNT_W'(1);
                // Only the most significant chunk carries the sign bit.
                if (chunk_diff_s && !decided_q) begin
                    eq_d      = 1'b0;
                    decided_d = 1'b1;
                    ltu_d     = chunk_ltu_s;
                    lt_d      = (cnt_q == '0) ? chunk_lts_s : chunk_ltu_s;
                end else begin
                    decided_d = decided_q;
                end
                if (cnt_q == LAST_CNT) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end else begin
`ifdef CMP32_EARLY_EXIT_EN
                    if (chunk_diff_s && !decided_q) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
`else
                    state_d = ST_RUN;
`endif
                end
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= 32'h0000_0000;
            y_q         <= 32'h0000_0000;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            ltu_q       <= 1'b0;
            decided_q   <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
            ltu_q       <= ltu_d;
            decided_q   <= decided_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_cmp32_seq.sv
// Self-checking bench for cmp32_seq: directed vectors with literal expectations plus
// a transaction-level model (queue of expected results and latencies) checked every cycle.
module tb_cmp32_seq;
    localparam int CHUNK_W = 8;
    localparam int NCH     = 32 / CHUNK_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmp32_seq_if bus();

    cmp32_seq #(.CHUNK_W(CHUNK_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit mon_en  = 1'b0;
    bit rnd_rdy = 1'b0;
    int n_acc   = 0;
    int n_done  = 0;

    typedef struct {
        bit eq;
        bit lt;
        bit ltu;
        bit sgn_diff;
        int lat;
        int acc;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycles from accept to out_valid, derived from where the operands first differ
    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        int first;
        d = a ^ b;
        first = NCH;
        for (int i = 0; i < 32; i++)
            if (d[i]) first = NCH - i / CHUNK_W;
`ifndef CMP32_EARLY_EXIT_EN
        first = NCH;
`endif
        return first;
    endfunction

    // Per-cycle comparison against the transaction model
    always @(negedge clk) begin
        bit pend;
        bit ov_exp;
        exp_t e;
        if (mon_en) begin
            pend   = (q.size() != 0);
            ov_exp = 1'b0;
            if (pend) ov_exp = ((cyc - q[0].acc) >= q[0].lat);
            check("busy", bus.busy, pend);
            check("in_ready", bus.in_ready, !pend && !rst);
            check("out_valid", bus.out_valid, ov_exp);
            if (ov_exp && bus.out_valid) begin
                check("equal", bus.equal, q[0].eq);
                check("lt", bus.lt, q[0].lt);
                check("ltu", bus.ltu, q[0].ltu);
                if (bus.equal) check("inv_eq_implies_not_lt", {bus.lt, bus.ltu}, 2'b00);
                if (bus.lt != bus.ltu) check("inv_lt_ltu_sign", q[0].sgn_diff, 1'b1);
            end
            if (rst) begin
                q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready && pend) begin
                    void'(q.pop_front());
                    n_done++;
                end
                if (bus.in_valid && bus.in_ready) begin
                    e.eq       = (bus.x == bus.y);
                    e.lt       = ($signed(bus.x) < $signed(bus.y));
                    e.ltu      = (bus.x < bus.y);
                    e.sgn_diff = (bus.x[31] != bus.y[31]);
                    e.lat      = exp_lat(bus.x, bus.y);
                    e.acc      = cyc + 1;
                    q.push_back(e);
                    n_acc++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (cyc > 40000) begin
            $display("FAIL watchdog: got cycle %0d expected below 40000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n;
        bus.x = a;
        bus.y = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready expected in_ready within 200 cycles");
        end
        step();
        bus.in_valid = 1'b0;
        bus.x = ~a;
        bus.y = a ^ b;
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input bit e_eq, input bit e_lt, input bit e_ltu,
                          input int lat_def, input int lat_early);
        int t0;
        int n;
        int lat;
`ifdef CMP32_EARLY_EXIT_EN
        lat = lat_early;
`else
        lat = lat_def;
`endif
        send(a, b);
        t0 = cyc;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            step();
            n++;
        end
        check({name, "_latency"}, cyc - t0, lat);
        check({name, "_equal"}, bus.equal, e_eq);
        check({name, "_lt"}, bus.lt, e_lt);
        check({name, "_ltu"}, bus.ltu, e_ltu);
        step();
    endtask

    initial begin
        int base_a;
        int base_d;
        int n;
        logic [31:0] a;
        logic [31:0] b;
        bus.in_valid  = 1'b0;
        bus.x         = 32'h0000_0000;
        bus.y         = 32'h0000_0000;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_equal", bus.equal, 1'b0);
        check("rst_lt", bus.lt, 1'b0);
        check("rst_ltu", bus.ltu, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;

        run_op("eq_a5", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0, 4, 4);
        run_op("eq_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 4, 4);
        run_op("sign_pos_neg", 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 4, 1);
        run_op("sign_neg_zero", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 4, 1);
        run_op("lsb_diff", 32'h1234_5678, 32'h1234_5679, 1'b0, 1'b1, 1'b1, 4, 4);

        // Backpressure: result held while in_valid and operands churn
        bus.out_ready = 1'b0;
        send(32'h0000_0005, 32'h0000_0003);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            step();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.x = $urandom;
            bus.y = $urandom;
            step();
            check("bp_out_valid", bus.out_valid, 1'b1);
            check("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_busy", bus.busy, 1'b1);
            check("bp_equal", bus.equal, 1'b0);
            check("bp_lt", bus.lt, 1'b0);
            check("bp_ltu", bus.ltu, 1'b0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_release_out_valid", bus.out_valid, 1'b1);
        step();
        check("bp_after_out_valid", bus.out_valid, 1'b0);
        check("bp_after_in_ready", bus.in_ready, 1'b1);

        // Reset in the middle of RUN discards the operation
        send(32'h0000_0000, 32'h0000_0001);
        step();
        rst = 1'b1;
        step();
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_equal", bus.equal, 1'b0);
        check("abort_lt", bus.lt, 1'b0);
        check("abort_ltu", bus.ltu, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        rst = 1'b0;
        run_op("after_abort", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 4, 4);

        // Sweep: half equal pairs, half single-bit differences, random gaps and backpressure
        base_a = n_acc;
        base_d = n_done;
        rnd_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) step();
            a = $urandom;
            b = ((i % 2) == 0) ? a : (a ^ (32'h0000_0001 << (i % 32)));
            send(a, b);
        end
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            step();
            n++;
        end
        rnd_rdy = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("sweep_accepts", n_acc - base_a, 200);
        check("sweep_results", n_done - base_d, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
